// File: rtl/pll_seq_pkg.sv
// Shared types and constants for the PLL rate sequencer: FSM states,
// reconfig register map and the two default fractional-K values.
package pll_seq_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_W_MODE,
      ST_W_FRAC,
      ST_W_C0,
      ST_W_START,
      ST_HOLDOFF,
      ST_WAIT_LOCK
   } seq_state_t;

   localparam logic [5:0] ADDR_MODE  = 6'd0;
   localparam logic [5:0] ADDR_START = 6'd2;
   localparam logic [5:0] ADDR_C     = 6'd5;
   localparam logic [5:0] ADDR_FRAC  = 6'd7;

   // Fractional K for the native video rate and the 60 Hz adjusted rate.
   localparam logic [31:0] K_NATIVE = 32'h0800_0000;
   localparam logic [31:0] K_60HZ   = 32'h07F2_A1C0;

   function automatic logic is_write_state(input seq_state_t s);
      return (s == ST_W_MODE) || (s == ST_W_FRAC) ||
             (s == ST_W_C0)   || (s == ST_W_START);
   endfunction

endpackage

// File: rtl/pll_seq_sync.sv
// Two-flop synchroniser with an optional stability counter; `stable` rises
// once the synchronised value has held for STABLE_CYCLES (always 1 when 0).
module pll_seq_sync #(
   parameter int W             = 1,
   parameter int STABLE_CYCLES = 16
) (
   input  logic         clk_50m,
   input  logic         reset,
   input  logic [W-1:0] d,
   output logic [W-1:0] q,
   output logic         stable
);

   logic [W-1:0] s1;
   logic [W-1:0] s2;

   always_ff @(posedge clk_50m or negedge reset) begin
      if (!reset) begin
         s1 <= '0;
         s2 <= '0;
      end else begin
         s1 <= d;
         s2 <= s1;
      end
   end

   assign q = s2;

   generate
      if (STABLE_CYCLES == 0) begin : g_bypass
         assign stable = 1'b1;
      end else begin : g_filter
         localparam int CW = $clog2(STABLE_CYCLES + 1);
         localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES);
         logic [CW-1:0] cnt;

         // Reload as the new value enters s2 so the count is for that value.
         always_ff @(posedge clk_50m or negedge reset) begin
            if (!reset)
               cnt <= '0;
            else if (s1 != s2)
               cnt <= '0;
            else if (cnt != CNT_MAX)
               cnt <= cnt + 1'b1;
         end

         assign stable = (cnt == CNT_MAX) && (s1 == s2);
      end
   endgenerate

endmodule

// File: rtl/pll_rate_sequencer.sv
// Reprograms the PLL fractional-K over its Avalon-MM reconfig port when the
// stable preset select changes, then supervises relock. Define PLLSEQ_C0_EN
// to also rewrite counter C0 per preset.
module pll_rate_sequencer
   import pll_seq_pkg::*;
#(
   parameter int NUM_PRESETS   = 4,
   parameter int SEL_W         = 2,
   parameter int STABLE_CYCLES = 16,
   parameter int LOCK_HOLDOFF  = 64,
   parameter int LOCK_TIMEOUT  = 2**20
) (
   input  logic                     clk_50m,
   input  logic                     reset,
   input  logic [SEL_W-1:0]         sel,
   input  logic [32*NUM_PRESETS-1:0] preset_frac,
`ifdef PLLSEQ_C0_EN
   input  logic [18*NUM_PRESETS-1:0] preset_c0,
`endif
   input  logic                     locked,
   input  logic                     cfg_waitrequest,
   output logic                     cfg_write,
   output logic [5:0]               cfg_address,
   output logic [31:0]              cfg_data,
   output logic                     busy,
   output logic [SEL_W-1:0]         active_sel,
   output logic                     done,
   output logic                     lock_err
);

   localparam int HOLD_W = $clog2(LOCK_HOLDOFF + 1);
   localparam int TO_W   = $clog2(LOCK_TIMEOUT + 1);
   localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LOCK_HOLDOFF);
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LOCK_HOLDOFF - 1);
   localparam logic [TO_W-1:0]   TO_MAX    = TO_W'(LOCK_TIMEOUT);
   localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(LOCK_TIMEOUT - 1);
   localparam logic [SEL_W:0]    NUM_P     = (SEL_W + 1)'(NUM_PRESETS);

   seq_state_t        state_q;
   seq_state_t        state_d;
   logic [SEL_W-1:0]  sel_s;
   logic              sel_stable;
   logic              locked_s;
   logic              locked_stable;
   logic              lock_ok;
   logic              req;
   logic [SEL_W-1:0]  target;
   logic              wr_done;
   logic [HOLD_W-1:0] hold_cnt;
   logic [TO_W-1:0]   to_cnt;
   logic              finish;
   logic [31:0]       frac_sel;

   pll_seq_sync #(.W(SEL_W), .STABLE_CYCLES(STABLE_CYCLES)) u_sel_sync (
      .clk_50m (clk_50m),
      .reset   (reset),
      .d       (sel),
      .q       (sel_s),
      .stable  (sel_stable)
   );

   pll_seq_sync #(.W(1), .STABLE_CYCLES(0)) u_lock_sync (
      .clk_50m (clk_50m),
      .reset   (reset),
      .d       (locked),
      .q       (locked_s),
      .stable  (locked_stable)
   );

   assign lock_ok  = locked_s & locked_stable;
   assign req      = sel_stable && (sel_s != active_sel) && ({1'b0, sel_s} < NUM_P);
   assign finish   = (state_q == ST_WAIT_LOCK) && (lock_ok || (to_cnt == TO_LAST));
   assign frac_sel = preset_frac[32*int'(target) +: 32];

   always_ff @(posedge clk_50m or negedge reset) begin
      if (!reset)
         state_q <= ST_IDLE;
      else
         state_q <= state_d;
   end

   // Each write state spends one idle cycle (wr_done) after acceptance.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:      if (req) state_d = ST_W_MODE;
         ST_W_MODE:    if (wr_done) state_d = ST_W_FRAC;
`ifdef PLLSEQ_C0_EN
         ST_W_FRAC:    if (wr_done) state_d = ST_W_C0;
         ST_W_C0:      if (wr_done) state_d = ST_W_START;
`else
         ST_W_FRAC:    if (wr_done) state_d = ST_W_START;
`endif
         ST_W_START:   if (wr_done) state_d = ST_HOLDOFF;
         ST_HOLDOFF:   if (hold_cnt == HOLD_LAST) state_d = ST_WAIT_LOCK;
         ST_WAIT_LOCK: if (finish) state_d = ST_IDLE;
         default:      state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      cfg_write   = is_write_state(state_q) && !wr_done;
      cfg_address = ADDR_MODE;
      cfg_data    = '0;
      case (state_q)
         ST_W_FRAC: begin
            cfg_address = ADDR_FRAC;
            cfg_data    = frac_sel;
         end
`ifdef PLLSEQ_C0_EN
         ST_W_C0: begin
            cfg_address = ADDR_C;
            cfg_data    = {14'b0, preset_c0[18*int'(target) +: 18]};
         end
`endif
         ST_W_START: cfg_address = ADDR_START;
         default: ;
      endcase
      busy = (state_q != ST_IDLE);
   end

   always_ff @(posedge clk_50m or negedge reset) begin
      if (!reset) begin
         target     <= '0;
         wr_done    <= 1'b0;
         hold_cnt   <= '0;
         to_cnt     <= '0;
         active_sel <= '0;
         done       <= 1'b0;
         lock_err   <= 1'b0;
      end else begin
         wr_done <= is_write_state(state_q) && !wr_done && !cfg_waitrequest;
         done    <= (state_q == ST_WAIT_LOCK) && lock_ok;

         if ((state_q == ST_IDLE) && req)
            target <= sel_s;

         if (state_q != ST_HOLDOFF)
            hold_cnt <= '0;
         else if (hold_cnt != HOLD_MAX)
            hold_cnt <= hold_cnt + 1'b1;

         if (state_q != ST_WAIT_LOCK)
            to_cnt <= '0;
         else if (to_cnt != TO_MAX)
            to_cnt <= to_cnt + 1'b1;

         // A timed-out preset is still recorded as applied, flagged by lock_err.
         if (finish) begin
            active_sel <= target;
            lock_err   <= !lock_ok;
         end
      end
   end

endmodule
